dc_sequencer: RTL and testbench

Upstream feeder for the PWM timer's external duty-cycle path.
- Buffers a queue of duty-cycle samples written over Wishbone.
- Releases one sample as o_dc plus a one-cycle o_dc_valid strobe every HOLD update ticks.
- i_tick is the PWM period-end strobe, so duty changes align to period boundaries.
- Single clock domain, same clock as the Wishbone bus.

---
 rtl/dc_sequencer_pkg.sv | 38 +++
 rtl/dc_sequencer_sync_fifo.sv | 83 ++++++++
 rtl/dc_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_dc_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dc_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// dc_sequencer_pkg
// Shared definitions for the duty-cycle sequencer:
//   - register address map (adr[2:0])
//   - CTRL / STATUS bit positions
//   - HOLD reset value and a helper that maps HOLD to its last count value
// Optional feature macro used by the importing files: DC_SEQ_LOOP_EN
// ---------------------------------------------------------------------------
package dc_sequencer_pkg;

  typedef enum logic [2:0] {
    ADR_CTRL    = 3'd0,
    ADR_STATUS  = 3'd1,
    ADR_DATA    = 3'd2,
    ADR_HOLD    = 3'd3,
    ADR_LOWMARK = 3'd4
  } reg_adr_e;

  // CTRL bits
  localparam int CTRL_EN     = 0;
  localparam int CTRL_LOOP   = 1;
  localparam int CTRL_CLR    = 2;
  localparam int CTRL_IRQ_EN = 3;

  // STATUS bits (level occupies [LVLW-1:0])
  localparam int ST_EMPTY    = 8;
  localparam int ST_FULL     = 9;
  localparam int ST_UNDERRUN = 10;
  localparam int ST_OVERFLOW = 11;

  localparam logic [15:0] HOLD_DEFAULT = 16'd1;

  // Terminal value of the hold counter; HOLD=0 behaves like HOLD=1.
  function automatic logic [15:0] hold_last(input logic [15:0] hold);
    return (hold == 16'd0) ? 16'd0 : hold - 16'd1;
  endfunction

endpackage

// File: rtl/dc_sequencer_sync_fifo.sv
// ---------------------------------------------------------------------------
// dc_sequencer_sync_fifo
// Synchronous FIFO with registered pointers and a level counter. Push and pop
// in the same cycle are both honoured, including when full (the slot being
// vacated is rewritten). i_clr flushes pointers and level and wins over push
// and pop.
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_push, i_pop, i_clr  push request, pop request, flush
//   i_din                 push data
//   o_dout                head entry (valid when !o_empty)
//   o_level               number of stored entries (0..DEPTH)
//   o_full, o_empty       level flags
//   i_peek_ofs, o_peek    (DC_SEQ_LOOP_EN only) read of entry head+ofs
// Macro: DC_SEQ_LOOP_EN adds the peek port used by loop replay.
// ---------------------------------------------------------------------------
module dc_sequencer_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int LVLW = AW + 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic            i_clr,
  input  logic [DW-1:0]   i_din,
`ifdef DC_SEQ_LOOP_EN
  input  logic [AW-1:0]   i_peek_ofs,
  output logic [DW-1:0]   o_peek,
`endif
  output logic [DW-1:0]   o_dout,
  output logic [LVLW-1:0] o_level,
  output logic            o_full,
  output logic            o_empty
);

  logic [DW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [LVLW-1:0] r_level;
  logic            w_do_push;
  logic            w_do_pop;

  assign o_full    = (r_level == LVLW'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_dout    = r_mem[r_rd_ptr];
`ifdef DC_SEQ_LOOP_EN
  assign o_peek    = r_mem[r_rd_ptr + i_peek_ofs];
`endif

  assign w_do_pop  = i_pop & ~o_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage carries no reset so it can map onto RAM.
  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_clr) r_mem[r_wr_ptr] <= i_din;
  end

endmodule

// File: rtl/dc_sequencer.sv
// ---------------------------------------------------------------------------
// dc_sequencer
// Wishbone-fed duty-cycle sample queue for the PWM timer. Every HOLD update
// ticks (i_tick = PWM period end) one sample is released on o_dc together
// with a one-cycle o_dc_valid strobe. Low-watermark interrupt on o_irq.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_wb_*           Wishbone slave (cyc, stb, we, 4-bit word adr, 16-bit data)
//   o_wb_ack         one-cycle registered acknowledge
//   o_wb_data        registered read data
//   i_tick           update strobe, one cycle wide
//   o_dc             current duty-cycle sample
//   o_dc_valid       one-cycle strobe, o_dc updated
//   o_irq            level-sensitive low-watermark interrupt
// Macro: DC_SEQ_LOOP_EN enables CTRL.LOOP (replay of the stored pattern).
// ---------------------------------------------------------------------------
module dc_sequencer #(
  parameter int DEPTH = 16,
  parameter int DW    = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_wb_cyc,
  input  logic          i_wb_stb,
  input  logic          i_wb_we,
  input  logic [3:0]    i_wb_adr,
  input  logic [15:0]   i_wb_data,
  output logic          o_wb_ack,
  output logic [15:0]   o_wb_data,
  input  logic          i_tick,
  output logic [DW-1:0] o_dc,
  output logic          o_dc_valid,
  output logic          o_irq
);
  import dc_sequencer_pkg::*;

  localparam int AW   = $clog2(DEPTH);
  localparam int LVLW = AW + 1;

  logic            r_en;
  logic            r_irq_en;
  logic [15:0]     r_hold;
  logic [15:0]     r_lowmark;
  logic [15:0]     r_hcnt;
  logic            r_underrun;
  logic            r_overflow;

  logic [2:0]      w_adr;
  logic            w_acc, w_wr, w_rd;
  logic            w_wr_ctrl, w_wr_status, w_wr_data;
  logic            w_clr, w_fire, w_emit, w_pop, w_hit;
  logic [DW-1:0]   w_head, w_emit_data;
  logic [LVLW-1:0] w_level;
  logic            w_full, w_empty;
  logic [15:0]     w_ctrl_rd, w_status, w_rdata;
  logic            w_unused;

  assign w_unused    = i_wb_adr[3];
  assign w_adr       = i_wb_adr[2:0];
  assign w_acc       = i_wb_cyc & i_wb_stb & ~o_wb_ack;
  assign w_wr        = w_acc & i_wb_we;
  assign w_rd        = w_acc & ~i_wb_we;
  assign w_wr_ctrl   = w_wr & (w_adr == ADR_CTRL);
  assign w_wr_status = w_wr & (w_adr == ADR_STATUS);
  assign w_wr_data   = w_wr & (w_adr == ADR_DATA);
  assign w_clr       = w_wr_ctrl & i_wb_data[CTRL_CLR];

  // Emit when the tick completes a HOLD period; CLR discards it.
  assign w_fire = r_en & i_tick & (r_hcnt >= hold_last(r_hold));
  assign w_emit = w_fire & ~w_clr;
  assign w_hit  = w_emit & ~w_empty;

`ifdef DC_SEQ_LOOP_EN
  logic            r_loop;
  logic [AW-1:0]   r_rp;
  logic [LVLW-1:0] w_rp_inc;
  logic [DW-1:0]   w_peek;

  assign w_rp_inc    = LVLW'(r_rp) + LVLW'(1);
  // rp is held at 0 outside loop mode, so peek equals the head then.
  assign w_emit_data = w_peek;
  assign w_pop       = w_hit & ~r_loop;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_loop <= 1'b0;
      r_rp   <= '0;
    end else begin
      if (w_wr_ctrl) r_loop <= i_wb_data[CTRL_LOOP];
      if (w_clr || !r_loop)
        r_rp <= '0;
      else if (w_hit)
        r_rp <= (w_rp_inc >= w_level) ? '0 : r_rp + 1'b1;
    end
  end
`else
  assign w_emit_data = w_head;
  assign w_pop       = w_hit;
`endif

  dc_sequencer_sync_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_push     (w_wr_data),
    .i_pop      (w_pop),
    .i_clr      (w_clr),
    .i_din      (DW'(i_wb_data)),
`ifdef DC_SEQ_LOOP_EN
    .i_peek_ofs (r_rp),
    .o_peek     (w_peek),
`endif
    .o_dout     (w_head),
    .o_level    (w_level),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  always_comb begin
    w_ctrl_rd              = '0;
    w_ctrl_rd[CTRL_EN]     = r_en;
    w_ctrl_rd[CTRL_IRQ_EN] = r_irq_en;
`ifdef DC_SEQ_LOOP_EN
    w_ctrl_rd[CTRL_LOOP]   = r_loop;
`else
    w_ctrl_rd[CTRL_LOOP]   = 1'b0;
`endif

    w_status               = '0;
    w_status[LVLW-1:0]     = w_level;
    w_status[ST_EMPTY]     = w_empty;
    w_status[ST_FULL]      = w_full;
    w_status[ST_UNDERRUN]  = r_underrun;
    w_status[ST_OVERFLOW]  = r_overflow;

    case (w_adr)
      ADR_CTRL:    w_rdata = w_ctrl_rd;
      ADR_STATUS:  w_rdata = w_status;
      ADR_DATA:    w_rdata = w_empty ? 16'h0 : 16'(w_head);
      ADR_HOLD:    w_rdata = r_hold;
      ADR_LOWMARK: w_rdata = r_lowmark;
      default:     w_rdata = 16'h0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wb_ack   <= 1'b0;
      o_wb_data  <= '0;
      o_dc       <= '0;
      o_dc_valid <= 1'b0;
      o_irq      <= 1'b0;
      r_en       <= 1'b0;
      r_irq_en   <= 1'b0;
      r_hold     <= HOLD_DEFAULT;
      r_lowmark  <= '0;
      r_hcnt     <= '0;
      r_underrun <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      o_wb_ack   <= w_acc;
      o_wb_data  <= w_rd ? w_rdata : 16'h0;
      o_irq      <= r_irq_en & r_en & (16'(w_level) <= r_lowmark);
      o_dc_valid <= w_hit;
      if (w_hit) o_dc <= w_emit_data;

      if (w_wr_ctrl) begin
        r_en     <= i_wb_data[CTRL_EN];
        r_irq_en <= i_wb_data[CTRL_IRQ_EN];
      end
      if (w_wr && (w_adr == ADR_HOLD))    r_hold    <= i_wb_data;
      if (w_wr && (w_adr == ADR_LOWMARK)) r_lowmark <= i_wb_data;

      if (w_clr || !r_en)
        r_hcnt <= '0;
      else if (i_tick)
        r_hcnt <= w_fire ? 16'd0 : r_hcnt + 16'd1;

      // Sticky flags: a new event in the same cycle beats a write-1 clear.
      if (w_clr) begin
        r_underrun <= 1'b0;
        r_overflow <= 1'b0;
      end else begin
        if (w_emit && w_empty)
          r_underrun <= 1'b1;
        else if (w_wr_status && i_wb_data[ST_UNDERRUN])
          r_underrun <= 1'b0;
        if (w_wr_data && w_full && !w_pop)
          r_overflow <= 1'b1;
        else if (w_wr_status && i_wb_data[ST_OVERFLOW])
          r_overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_dc_sequencer
// Directed bench for dc_sequencer with a queue-based reference model checked
// every cycle, plus hand-computed register and output expectations.
// Macro: DC_SEQ_LOOP_EN adds the loop replay scenario.
// ---------------------------------------------------------------------------
module tb_dc_sequencer;
  localparam int DEPTH = 16;
  localparam int DW    = 16;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, tick = 1'b0;
  logic [3:0]  adr   = 4'd0;
  logic [15:0] wdata = 16'd0;
  logic        ack;
  logic [15:0] rdata;
  logic [15:0] dc;
  logic        dc_valid, irq;

  always #5 clk = ~clk;

  dc_sequencer #(.DEPTH(DEPTH), .DW(DW)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_wb_cyc   (cyc),
    .i_wb_stb   (stb),
    .i_wb_we    (we),
    .i_wb_adr   (adr),
    .i_wb_data  (wdata),
    .o_wb_ack   (ack),
    .o_wb_data  (rdata),
    .i_tick     (tick),
    .o_dc       (dc),
    .o_dc_valid (dc_valid),
    .o_irq      (irq)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          mq[$];
  int          m_hold = 1, m_low = 0, m_hcnt = 0, m_rp = 0;
  bit          m_en = 0, m_loop = 0, m_irqen = 0, m_ur = 0, m_ov = 0;
  logic [15:0] m_dc = 0, m_rdata = 0;
  logic        m_valid = 0, m_irq = 0, m_ack = 0, m_rd = 0;

  task automatic model_step();
    int a, lvl, hold_eff;
    bit acc, wr, rd, clr, emit, popped, nl;
    logic [15:0] rv;
    a        = int'(adr[2:0]);
    lvl      = mq.size();
    hold_eff = (m_hold == 0) ? 1 : m_hold;
    acc      = cyc && stb && !m_ack;
    wr       = acc && we;
    rd       = acc && !we;
    clr      = wr && (a == 0) && wdata[2];
    case (a)
      0: rv = {12'd0, m_irqen, 1'b0, m_loop, m_en};
      1: rv = 16'(lvl) | ((lvl == 0) ? 16'h0100 : 16'h0) | ((lvl == DEPTH) ? 16'h0200 : 16'h0)
            | (m_ur ? 16'h0400 : 16'h0) | (m_ov ? 16'h0800 : 16'h0);
      2: rv = (lvl == 0) ? 16'h0 : 16'(mq[0]);
      3: rv = 16'(m_hold);
      4: rv = 16'(m_low);
      default: rv = 16'h0;
    endcase
    m_ack   = acc;
    m_rd    = rd;
    m_rdata = rd ? rv : 16'h0;
    m_irq   = m_irqen && m_en && (lvl <= m_low);
    emit    = m_en && tick && (m_hcnt + 1 >= hold_eff);
    m_valid = 0;
    popped  = 0;
    if (clr) begin
      mq.delete();
      m_hcnt = 0; m_ur = 0; m_ov = 0; m_rp = 0;
    end else begin
      if (!m_en) m_hcnt = 0;
      else if (tick) m_hcnt = emit ? 0 : m_hcnt + 1;
      if (wr && a == 1) begin
        if (wdata[10]) m_ur = 0;
        if (wdata[11]) m_ov = 0;
      end
      if (emit) begin
        if (lvl == 0) m_ur = 1;
        else if (m_loop) begin
          m_dc = 16'(mq[m_rp]); m_valid = 1; m_rp = (m_rp + 1) % lvl;
        end else begin
          m_dc = 16'(mq[0]); m_valid = 1; popped = 1;
        end
      end
      if (wr && a == 2) begin
        if (lvl == DEPTH && !popped) m_ov = 1;
        else mq.push_back(int'(wdata));
      end
      if (popped) mq.delete(0);
    end
    if (wr && a == 0) begin
      m_en    = wdata[0];
      m_irqen = wdata[3];
`ifdef DC_SEQ_LOOP_EN
      nl = wdata[1];
      if (nl && !m_loop) m_rp = 0;
      m_loop = nl;
`else
      nl = 0;
      m_loop = nl;
`endif
    end
    if (!m_loop) m_rp = 0;
    if (wr && a == 3) m_hold = int'(wdata);
    if (wr && a == 4) m_low  = int'(wdata);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_hold = 1; m_low = 0; m_hcnt = 0; m_rp = 0;
      m_en = 0; m_loop = 0; m_irqen = 0; m_ur = 0; m_ov = 0;
      m_dc = 0; m_rdata = 0; m_valid = 0; m_irq = 0; m_ack = 0; m_rd = 0;
    end else begin
      model_step();
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    chk("o_dc", 32'(dc), 32'(m_dc));
    chk("o_dc_valid", 32'(dc_valid), 32'(m_valid));
    chk("o_irq", 32'(irq), 32'(m_irq));
    chk("o_wb_ack", 32'(ack), 32'(m_ack));
    if (m_ack && m_rd) chk("o_wb_data", 32'(rdata), 32'(m_rdata));
  end

  // ---------------- stimulus helpers ----------------
  task automatic wb_write(input logic [3:0] a, input logic [15:0] d);
    @(negedge clk); cyc = 1; stb = 1; we = 1; adr = a; wdata = d;
    @(negedge clk); cyc = 0; stb = 0; we = 0;
    $display("WR  adr=%0d data=0x%04h", a, d);
  endtask

  task automatic wb_read(input logic [3:0] a, output logic [15:0] d);
    @(negedge clk); cyc = 1; stb = 1; we = 0; adr = a;
    @(negedge clk); d = rdata; cyc = 0; stb = 0;
    $display("RD  adr=%0d data=0x%04h", a, d);
  endtask

  task automatic rd_chk(input string name, input logic [3:0] a, input logic [15:0] exp);
    logic [15:0] d;
    wb_read(a, d);
    chk(name, 32'(d), 32'(exp));
  endtask

  task automatic do_tick(output logic v, output logic [15:0] d);
    @(negedge clk); tick = 1;
    @(negedge clk); tick = 0; v = dc_valid; d = dc;
    $display("TICK valid=%0d dc=0x%04h", v, d);
  endtask

  task automatic tick_write(input logic [3:0] a, input logic [15:0] d,
                            output logic v, output logic [15:0] o);
    @(negedge clk); tick = 1; cyc = 1; stb = 1; we = 1; adr = a; wdata = d;
    @(negedge clk); tick = 0; cyc = 0; stb = 0; we = 0; v = dc_valid; o = dc;
    $display("TICK+WR adr=%0d data=0x%04h valid=%0d dc=0x%04h", a, d, v, o);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic        v;
    logic [15:0] d;

    repeat (3) @(negedge clk);
    rst_n = 1;

    // Reset defaults
    rd_chk("rst_ctrl", 4'd0, 16'h0000);
    rd_chk("rst_status", 4'd1, 16'h0100);
    rd_chk("rst_hold", 4'd3, 16'h0001);
    rd_chk("rst_lowmark", 4'd4, 16'h0000);

    // Basic sequencing, HOLD=2
    wb_write(4'd2, 16'd100);
    wb_write(4'd2, 16'd200);
    wb_write(4'd2, 16'd300);
    rd_chk("data_head", 4'd2, 16'd100);
    wb_write(4'd3, 16'd2);
    wb_write(4'd0, 16'h0001);
    for (int i = 1; i <= 6; i++) begin
      do_tick(v, d);
      chk("seq_valid", 32'(v), (i % 2 == 0) ? 32'd1 : 32'd0);
      if (i % 2 == 0) chk("seq_dc", 32'(d), 32'(100 * (i / 2)));
    end
    rd_chk("seq_status", 4'd1, 16'h0100);

    // Underrun
    wb_write(4'd3, 16'd1);
    for (int i = 0; i < 2; i++) begin
      do_tick(v, d);
      chk("ur_valid", 32'(v), 32'd0);
      chk("ur_dc_hold", 32'(d), 32'd300);
    end
    rd_chk("ur_status", 4'd1, 16'h0500);
    wb_write(4'd1, 16'h0400);
    rd_chk("ur_cleared", 4'd1, 16'h0100);

    // Overflow, then push+pop while full
    wb_write(4'd0, 16'h0000);
    for (int i = 0; i <= DEPTH; i++) wb_write(4'd2, 16'(1000 + i));
    rd_chk("ov_status", 4'd1, 16'h0A10);
    wb_write(4'd0, 16'h0001);
    tick_write(4'd2, 16'h7777, v, d);
    chk("full_pp_valid", 32'(v), 32'd1);
    chk("full_pp_dc", 32'(d), 32'd1000);
    rd_chk("full_pp_status", 4'd1, 16'h0A10);
    for (int i = 0; i < DEPTH; i++) begin
      do_tick(v, d);
      chk("drain_valid", 32'(v), 32'd1);
      chk("drain_dc", 32'(d), (i < DEPTH - 1) ? 32'(1001 + i) : 32'h7777);
    end
    rd_chk("drain_status", 4'd1, 16'h0900);
    wb_write(4'd1, 16'h0800);
    rd_chk("ov_cleared", 4'd1, 16'h0100);

    // Low-watermark interrupt
    wb_write(4'd2, 16'd11);
    wb_write(4'd2, 16'd22);
    wb_write(4'd2, 16'd33);
    wb_write(4'd2, 16'd44);
    wb_write(4'd4, 16'd2);
    wb_write(4'd0, 16'h0009);
    chk("irq_lvl4", 32'(irq), 32'd0);
    do_tick(v, d);
    chk("irq_dc11", 32'(d), 32'd11);
    do_tick(v, d);
    chk("irq_dc22", 32'(d), 32'd22);
    chk("irq_lvl2_same", 32'(irq), 32'd0);
    @(negedge clk);
    chk("irq_lvl2_next", 32'(irq), 32'd1);

    // CLR during an emit tick
    tick_write(4'd0, 16'h000D, v, d);
    chk("clr_valid", 32'(v), 32'd0);
    chk("clr_dc", 32'(d), 32'd22);
    rd_chk("clr_status", 4'd1, 16'h0100);
    rd_chk("clr_ctrl", 4'd0, 16'h0009);

`ifdef DC_SEQ_LOOP_EN
    // Loop replay
    wb_write(4'd0, 16'h0000);
    wb_write(4'd2, 16'd10);
    wb_write(4'd2, 16'd20);
    wb_write(4'd0, 16'h0003);
    for (int i = 0; i < 5; i++) begin
      do_tick(v, d);
      chk("loop_valid", 32'(v), 32'd1);
      chk("loop_dc", 32'(d), (i % 2 == 0) ? 32'd10 : 32'd20);
    end
    rd_chk("loop_status", 4'd1, 16'h0002);
    wb_write(4'd0, 16'h0001);
    do_tick(v, d);
    chk("unloop_dc", 32'(d), 32'd10);
`else
    rd_chk("loop_ro", 4'd0, 16'h0009);
    wb_write(4'd0, 16'h000B);
    rd_chk("loop_ignored", 4'd0, 16'h0009);
`endif

    // Asynchronous reset mid-sequence
    wb_write(4'd0, 16'h000D);
    wb_write(4'd2, 16'h0055);
    do_tick(v, d);
    chk("pre_rst_dc", 32'(d), 32'h55);
    chk("pre_rst_valid", 32'(v), 32'd1);
    chk("pre_rst_irq", 32'(irq), 32'd1);
    #2 rst_n = 0;
    #1;
    $display("RESET asserted");
    chk("arst_dc", 32'(dc), 32'd0);
    chk("arst_valid", 32'(dc_valid), 32'd0);
    chk("arst_irq", 32'(irq), 32'd0);
    chk("arst_ack", 32'(ack), 32'd0);
    chk("arst_wbdata", 32'(rdata), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    rd_chk("post_rst_ctrl", 4'd0, 16'h0000);
    rd_chk("post_rst_status", 4'd1, 16'h0100);
    rd_chk("post_rst_hold", 4'd3, 16'h0001);
    rd_chk("post_rst_lowmark", 4'd4, 16'h0000);
    rd_chk("post_rst_data", 4'd2, 16'h0000);
    rd_chk("unmapped_rd", 4'd6, 16'h0000);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
